cam_frame_seq: RTL and testbench

Frame-capture sequencer for the camera + AL422 FIFO path. On a capture request it:
- resets the FIFO write pointer;
- gates the FIFO write enable for exactly one VSYNC-delimited frame;
- resets the read pointer;
- paces the FIFO read clock to drain a fixed number of bytes into a valid/ready byte stream toward the Wishbone-side buffer.

It replaces free-running level control of we/rdclk/wrst/rrst/oe with a single owned sequence.

---
 rtl/cam_pkg.sv | 28 ++
 rtl/cam_frame_seq_if.sv | 28 ++
 rtl/cam_vsync_sync.sv | 35 +++
 rtl/cam_frame_seq.sv | 232 +++++++++++++++++++++++
 tb/tb_cam_frame_seq.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cam_pkg.sv
// Shared definitions for the camera frame-capture path.
//   cam_state_e        : sequencer states
//   QVGA_RGB565_BYTES  : bytes in one 320x240 RGB565 frame
//   DEFAULT_CLK_DIV    : default fifo_rclk half-period in clk cycles
//   DEFAULT_RST_CYCLES : default width of the FIFO pointer-reset pulses
//   cnt_width()        : width of a counter that counts 0..n-1 (never 0)
package cam_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRST,
        WAIT_HI,
        WAIT_FALL,
        WRITE,
        RRST,
        READ,
        DONE
    } cam_state_e;

    localparam int QVGA_RGB565_BYTES  = 153600;
    localparam int DEFAULT_CLK_DIV    = 4;
    localparam int DEFAULT_RST_CYCLES = 8;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cam_frame_seq_if.sv
// Byte stream from the frame sequencer toward the Wishbone-side buffer.
//   pix_data  : byte payload
//   pix_valid : pix_data holds a byte
//   pix_ready : consumer accepts the byte this cycle
//   pix_last  : final byte of the frame, qualified by pix_valid
// master = byte source (sequencer), slave = consumer.
interface cam_frame_seq_if;

    logic [7:0] pix_data;
    logic       pix_valid;
    logic       pix_ready;
    logic       pix_last;

    modport master (
        output pix_data,
        output pix_valid,
        output pix_last,
        input  pix_ready
    );

    modport slave (
        input  pix_data,
        input  pix_valid,
        input  pix_last,
        output pix_ready
    );

endinterface

// File: rtl/cam_vsync_sync.sv
// Brings the asynchronous camera VSYNC into the clk domain and flags edges.
//   clk, reset : system clock, synchronous active-high reset
//   vsync      : raw camera VSYNC
//   vs_lvl     : synchronized level
//   vs_rise    : one-cycle pulse on a synchronized 0->1 transition
//   vs_fall    : one-cycle pulse on a synchronized 1->0 transition
// Latency from raw edge to pulse is two clk cycles; a consumer registering
// on the pulse therefore reacts on the third edge.
module cam_vsync_sync (
    input  logic clk,
    input  logic reset,
    input  logic vsync,
    output logic vs_lvl,
    output logic vs_rise,
    output logic vs_fall
);

    logic [1:0] sync_reg;
    logic       prev_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg <= 2'b00;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], vsync};
            prev_reg <= sync_reg[1];
        end
    end

    assign vs_lvl  = sync_reg[1];
    assign vs_rise =  sync_reg[1] & ~prev_reg;
    assign vs_fall = ~sync_reg[1] &  prev_reg;

endmodule

// File: rtl/cam_frame_seq.sv
// Frame-capture sequencer for the camera + AL422 FIFO path.
// On start: pulse the FIFO write-pointer reset, wait for a full VSYNC-low
// period and enable FIFO writes for exactly that frame, pulse the read-pointer
// reset, then clock FRAME_BYTES bytes out of the FIFO into a valid/ready
// byte stream.
//   clk, reset    : system clock, synchronous active-high reset
//   start         : capture request (honoured only when idle)
//   abort         : return to idle on the next cycle from any state
//   vsync         : raw camera VSYNC
//   fifo_din      : AL422 read data
//   fifo_we_n     : AL422 write enable (active low)
//   fifo_wrst_n   : AL422 write-pointer reset (active low)
//   fifo_rrst_n   : AL422 read-pointer reset (active low)
//   fifo_oe_n     : AL422 output enable (active low)
//   fifo_rclk     : AL422 read clock
//   pix           : byte stream toward the buffer (master side)
//   busy          : high whenever a sequence is in progress
//   done          : one-cycle pulse after the last byte is accepted
// Every FIFO-facing output is a register decoded from the next state, so the
// pins are glitch-free and follow the state with no extra latency.
module cam_frame_seq
    import cam_pkg::*;
#(
    parameter int CLK_DIV     = DEFAULT_CLK_DIV,
    parameter int FRAME_BYTES = QVGA_RGB565_BYTES,
    parameter int RST_CYCLES  = DEFAULT_RST_CYCLES
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic            vsync,
    input  logic [7:0]      fifo_din,
    output logic            fifo_we_n,
    output logic            fifo_wrst_n,
    output logic            fifo_rrst_n,
    output logic            fifo_oe_n,
    output logic            fifo_rclk,
    cam_frame_seq_if.master pix,
    output logic            busy,
    output logic            done
);

    localparam int BW = $clog2(FRAME_BYTES + 1);
    localparam int RW = cnt_width(RST_CYCLES);
    localparam int DW = cnt_width(CLK_DIV);

    localparam logic [BW-1:0] LAST_IDX = BW'(FRAME_BYTES - 1);
    localparam logic [RW-1:0] RST_MAX  = RW'(RST_CYCLES - 1);
    localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);

    cam_state_e    state_reg, state_next;
    logic [RW-1:0] rst_cnt_reg, rst_cnt_next;
    logic [DW-1:0] div_reg, div_next;
    logic [BW-1:0] byte_cnt_reg, byte_cnt_next;
    logic          rclk_reg, rclk_next;
    logic          pix_valid_reg, pix_valid_next;
    logic [7:0]    pix_data_reg, pix_data_next;
    logic          we_n_reg, we_n_next;
    logic          wrst_n_reg, wrst_n_next;
    logic          rrst_n_reg, rrst_n_next;
    logic          oe_n_reg, oe_n_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;

    logic vs_lvl, vs_rise, vs_fall;
    logic handshake;
    logic stalled;

    cam_vsync_sync u_vsync_sync (
        .clk     (clk),
        .reset   (reset),
        .vsync   (vsync),
        .vs_lvl  (vs_lvl),
        .vs_rise (vs_rise),
        .vs_fall (vs_fall)
    );

    assign handshake = pix_valid_reg & pix.pix_ready;
    // A byte is waiting on the consumer: rclk and its divider hold still so
    // the FIFO is not advanced past an unaccepted byte.
    assign stalled   = pix_valid_reg & ~pix.pix_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            rst_cnt_reg   <= '0;
            div_reg       <= '0;
            byte_cnt_reg  <= '0;
            rclk_reg      <= 1'b0;
            pix_valid_reg <= 1'b0;
            pix_data_reg  <= 8'h00;
            we_n_reg      <= 1'b1;
            wrst_n_reg    <= 1'b1;
            rrst_n_reg    <= 1'b1;
            oe_n_reg      <= 1'b1;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rst_cnt_reg   <= rst_cnt_next;
            div_reg       <= div_next;
            byte_cnt_reg  <= byte_cnt_next;
            rclk_reg      <= rclk_next;
            pix_valid_reg <= pix_valid_next;
            pix_data_reg  <= pix_data_next;
            we_n_reg      <= we_n_next;
            wrst_n_reg    <= wrst_n_next;
            rrst_n_reg    <= rrst_n_next;
            oe_n_reg      <= oe_n_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        rst_cnt_next   = rst_cnt_reg;
        div_next       = div_reg;
        byte_cnt_next  = byte_cnt_reg;
        rclk_next      = rclk_reg;
        pix_valid_next = pix_valid_reg;
        pix_data_next  = pix_data_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next   = WRST;
                    rst_cnt_next = '0;
                end
            end
            WRST: begin
                if (rst_cnt_reg == RST_MAX) begin
                    state_next   = WAIT_HI;
                    rst_cnt_next = '0;
                end else begin
                    rst_cnt_next = rst_cnt_reg + 1'b1;
                end
            end
            // Waiting for VSYNC high first means a frame already in progress
            // at start is skipped rather than captured partially.
            WAIT_HI: begin
                if (vs_lvl) begin
                    state_next = WAIT_FALL;
                end
            end
            WAIT_FALL: begin
                if (vs_fall) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (vs_rise) begin
                    state_next = RRST;
                end
            end
            RRST: begin
                if (rst_cnt_reg == RST_MAX) begin
                    state_next   = READ;
                    rst_cnt_next = '0;
                end else begin
                    rst_cnt_next = rst_cnt_reg + 1'b1;
                end
            end
            READ: begin
                if (handshake) begin
                    pix_valid_next = 1'b0;
                    byte_cnt_next  = byte_cnt_reg + 1'b1;
                    if (byte_cnt_reg == LAST_IDX) begin
                        state_next = DONE;
                    end
                end
                if (!stalled) begin
                    if (div_reg == DIV_MAX) begin
                        div_next  = '0;
                        rclk_next = ~rclk_reg;
                        // Data was launched by the preceding rclk rise and
                        // has had a full high phase to settle.
                        if (rclk_reg) begin
                            pix_data_next  = fifo_din;
                            pix_valid_next = 1'b1;
                        end
                    end else begin
                        div_next = div_reg + 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (abort) begin
            state_next = IDLE;
        end

        // Read clock and stream are only alive inside READ; leaving it by any
        // path (completion or abort) parks them without a handshake.
        if (state_next != READ) begin
            rclk_next      = 1'b0;
            div_next       = '0;
            pix_valid_next = 1'b0;
        end
        if (state_next == IDLE) begin
            rst_cnt_next  = '0;
            byte_cnt_next = '0;
            pix_data_next = 8'h00;
        end

        we_n_next   = (state_next != WRITE);
        wrst_n_next = (state_next != WRST);
        rrst_n_next = (state_next != RRST);
        oe_n_next   = !((state_next == RRST) || (state_next == READ));
        busy_next   = (state_next != IDLE);
        done_next   = (state_next == DONE);
    end

    assign fifo_we_n     = we_n_reg;
    assign fifo_wrst_n   = wrst_n_reg;
    assign fifo_rrst_n   = rrst_n_reg;
    assign fifo_oe_n     = oe_n_reg;
    assign fifo_rclk     = rclk_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;
    assign pix.pix_data  = pix_data_reg;
    assign pix.pix_valid = pix_valid_reg;
    assign pix.pix_last  = pix_valid_reg && (byte_cnt_reg == LAST_IDX);

endmodule

// File: tb/tb_cam_frame_seq.sv
// Directed bench for cam_frame_seq with FRAME_BYTES=16, CLK_DIV=2,
// RST_CYCLES=4. A small AL422 read-side model returns 0x00, 0x01, ... after
// each read-pointer reset. A negedge monitor records pulse widths, edge
// cycles and stream handshakes; the main sequence compares them against
// hand-computed values.
module tb_cam_frame_seq;

    localparam int FB = 16;
    localparam int CD = 2;
    localparam int RC = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       vsync = 1'b0;
    logic [7:0] fifo_din = 8'h00;
    logic       fifo_we_n, fifo_wrst_n, fifo_rrst_n, fifo_oe_n, fifo_rclk;
    logic       busy, done;
    logic       ready_drv = 1'b1;

    cam_frame_seq_if pix ();
    assign pix.pix_ready = ready_drv;

    cam_frame_seq #(
        .CLK_DIV     (CD),
        .FRAME_BYTES (FB),
        .RST_CYCLES  (RC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .vsync       (vsync),
        .fifo_din    (fifo_din),
        .fifo_we_n   (fifo_we_n),
        .fifo_wrst_n (fifo_wrst_n),
        .fifo_rrst_n (fifo_rrst_n),
        .fifo_oe_n   (fifo_oe_n),
        .fifo_rclk   (fifo_rclk),
        .pix         (pix),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // AL422 read side: pointer cleared by rrst_n, each rclk rise presents
    // the next byte.
    int rd_ptr = 0;
    always @(posedge fifo_rclk or negedge fifo_rrst_n) begin
        if (!fifo_rrst_n) begin
            rd_ptr <= 0;
        end else begin
            fifo_din <= 8'(rd_ptr);
            rd_ptr   <= rd_ptr + 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor state (written only by the monitor; main reads deltas).
    int   wrst_cnt = 0, wrst_first = 0;
    int   we_cnt = 0, we_first = 0, we_last = 0;
    int   rrst_cnt = 0, rrst_first = 0;
    int   done_cnt = 0, done_cyc = 0;
    int   busy_seen = 0;
    logic busy_after_done = 1'b1;
    logic done_pending = 1'b0;
    logic wrst_prev = 1'b1, we_prev = 1'b1, rrst_prev = 1'b1;
    logic stall_en = 1'b0;
    logic stall_done = 1'b0;
    int   stall_cycles = 0, rclk_in_stall = 0;
    int   got_q[$];
    int   last_q[$];
    int   hs_q[$];

    wire stall_now = stall_en && !stall_done && pix.pix_valid && (pix.pix_data == 8'h05);

    always @(negedge clk) begin
        if (!fifo_wrst_n) begin
            if (wrst_prev) wrst_first <= cyc;
            wrst_cnt <= wrst_cnt + 1;
        end
        wrst_prev <= fifo_wrst_n;
        if (!fifo_we_n) begin
            if (we_prev) we_first <= cyc;
            we_last <= cyc;
            we_cnt  <= we_cnt + 1;
        end
        we_prev <= fifo_we_n;
        if (!fifo_rrst_n) begin
            if (rrst_prev) rrst_first <= cyc;
            rrst_cnt <= rrst_cnt + 1;
        end
        rrst_prev <= fifo_rrst_n;
        if (done_pending) busy_after_done <= busy;
        done_pending <= done;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (busy) busy_seen <= busy_seen + 1;
        // Consumer: hold off byte 0x05 for seven cycles once stalling is on.
        if (stall_now) begin
            ready_drv    <= 1'b0;
            stall_cycles <= stall_cycles + 1;
            if (fifo_rclk) rclk_in_stall <= rclk_in_stall + 1;
            if (stall_cycles == 6) stall_done <= 1'b1;
        end else begin
            ready_drv <= 1'b1;
        end
        if (pix.pix_valid && !stall_now) begin
            got_q.push_back(int'(pix.pix_data));
            last_q.push_back(int'(pix.pix_last));
            hs_q.push_back(cyc);
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int base, input string tag);
        int i;
        i = 0;
        while (done_cnt == base && i < 400) begin
            tick();
            i++;
        end
        check(tag, 32'(done_cnt > base), 1);
    endtask

    task automatic check_frame(input string tag, input int q0);
        for (int i = 0; i < FB; i++) begin
            if (q0 + i < got_q.size()) begin
                $display("%s byte %0d: data=0x%02h last=%0d cycle=%0d",
                         tag, i, got_q[q0+i], last_q[q0+i], hs_q[q0+i]);
                check({tag, "_data"}, got_q[q0+i], i);
                check({tag, "_last"}, last_q[q0+i], (i == FB - 1) ? 1 : 0);
            end
        end
    endtask

    initial begin
        int t_start, t_fall, t_rise, q0, bad;
        int b_busy, b_wrst, b_we, b_rrst, b_done;

        // Reset held with VSYNC toggling and start asserted.
        start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vsync = ~vsync;
            tick();
        end
        $display("reset: checking idle outputs");
        check("rst_we_n",   fifo_we_n,     1);
        check("rst_wrst_n", fifo_wrst_n,   1);
        check("rst_rrst_n", fifo_rrst_n,   1);
        check("rst_oe_n",   fifo_oe_n,     1);
        check("rst_rclk",   fifo_rclk,     0);
        check("rst_valid",  pix.pix_valid, 0);
        check("rst_last",   pix.pix_last,  0);
        check("rst_data",   pix.pix_data,  0);
        check("rst_busy",   busy,          0);
        check("rst_done",   done,          0);

        start = 1'b0;
        reset = 1'b0;
        b_busy = busy_seen;
        for (int i = 0; i < 20; i++) begin
            vsync = i[2];
            tick();
        end
        vsync = 1'b0;
        repeat (5) tick();
        check("idle_busy_cycles", busy_seen - b_busy, 0);

        // Capture A: full-speed read, extra start pulses in WRITE and READ.
        $display("capture A: 40-cycle VSYNC low, pix_ready held high");
        b_wrst = wrst_cnt; b_we = we_cnt; b_rrst = rrst_cnt; b_done = done_cnt;
        q0 = got_q.size();
        t_start = cyc;
        pulse_start();
        repeat (2) tick();
        vsync = 1'b1;
        repeat (10) tick();
        vsync = 1'b0;
        t_fall = cyc;
        repeat (20) tick();
        pulse_start();
        repeat (19) tick();
        vsync = 1'b1;
        t_rise = cyc;
        repeat (30) tick();
        pulse_start();
        wait_done(b_done, "A_done_seen");
        repeat (10) tick();
        check("A_wrst_len",    wrst_cnt - b_wrst, RC);
        check("A_wrst_start",  wrst_first - t_start, 1);
        check("A_we_len",      we_cnt - b_we, 40);
        check("A_we_fall_lat", we_first - t_fall, 3);
        check("A_we_rise_lat", we_last + 1 - t_rise, 3);
        check("A_rrst_len",    rrst_cnt - b_rrst, RC);
        check("A_rrst_lat",    rrst_first - t_rise, 3);
        check("A_nbytes",      got_q.size() - q0, FB);
        check_frame("A", q0);
        if (got_q.size() >= q0 + FB) begin
            check("A_first_byte_lat", hs_q[q0] - rrst_first, RC + 2 * CD);
            bad = 0;
            for (int i = 1; i < FB; i++) begin
                if (hs_q[q0+i] - hs_q[q0+i-1] != 2 * CD) bad++;
            end
            check("A_byte_spacing", bad, 0);
            check("A_done_lat", done_cyc - hs_q[q0+FB-1], 1);
        end
        check("A_busy_after_done", busy_after_done, 0);
        check("A_done_count", done_cnt - b_done, 1);

        // Capture B: abort in the third cycle of READ.
        $display("capture B: abort in READ cycle 3");
        b_done = done_cnt;
        pulse_start();
        repeat (2) tick();
        vsync = 1'b1;
        repeat (10) tick();
        vsync = 1'b0;
        repeat (20) tick();
        vsync = 1'b1;
        t_rise = cyc;
        repeat (RC + 5) tick();
        check("B_read_oe_n",   fifo_oe_n,   0);
        check("B_read_rrst_n", fifo_rrst_n, 1);
        check("B_rclk_rise",   fifo_rclk,   1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("B_abort_busy",  busy,          0);
        check("B_abort_oe_n",  fifo_oe_n,     1);
        check("B_abort_rclk",  fifo_rclk,     0);
        check("B_abort_valid", pix.pix_valid, 0);
        repeat (80) tick();
        check("B_no_done", done_cnt - b_done, 0);
        check("B_idle_busy", busy, 0);

        // Capture C: consumer stalls on byte 0x05 for seven cycles.
        $display("capture C: pix_ready low 7 cycles on byte 0x05");
        stall_en = 1'b1;
        b_done = done_cnt;
        q0 = got_q.size();
        pulse_start();
        repeat (2) tick();
        vsync = 1'b1;
        repeat (10) tick();
        vsync = 1'b0;
        repeat (20) tick();
        vsync = 1'b1;
        wait_done(b_done, "C_done_seen");
        repeat (5) tick();
        check("C_nbytes", got_q.size() - q0, FB);
        check_frame("C", q0);
        check("C_stall_cycles", stall_cycles, 7);
        check("C_rclk_in_stall", rclk_in_stall, 0);
        check("C_done_count", done_cnt - b_done, 1);
        check("C_idle_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
